// File: rtl/if_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_fetch_unit: IF stage - PC register, fetch request, IF/ID register    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module if_fetch_unit #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter int          TEXT_WORDS = 4096,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        br_in_id,
  input  logic        exc_enter,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] rom_pc,
  output logic        rom_sel,
  input  logic [31:0] rom_d,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_bd,
  output logic [4:0]  id_exccode
);

  // 33-bit end bound so a text segment reaching the top of memory does not wrap
  localparam logic [32:0] TEXT_END = {1'b0, TEXT_BASE} + (33'(TEXT_WORDS) << 2);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        legal;
  logic        flush;

  assign legal   = (pc[1:0] == 2'b00) && (pc >= TEXT_BASE) && ({1'b0, pc} < TEXT_END);
  assign rom_pc  = pc;
  assign rom_sel = legal;
  assign flush   = exc_enter | eret;

  always_comb begin
    pc_next = pc + 32'd4;
    if (exc_enter)    pc_next = HANDLER_PC;
    else if (eret)    pc_next = epc;
    else if (stall)   pc_next = pc;
    else if (br_take) pc_next = br_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= TEXT_BASE;
    else       pc <= pc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr   <= 32'd0;
      id_pc      <= 32'd0;
      id_pc8     <= 32'd0;
      id_valid   <= 1'b0;
      id_bd      <= 1'b0;
      id_exccode <= 5'd0;
    end else if (flush) begin
      // bubble still carries the flushed PC so later stages see a sane address
      id_instr   <= 32'd0;
      id_pc      <= pc;
      id_pc8     <= pc + 32'd8;
      id_valid   <= 1'b0;
      id_bd      <= 1'b0;
      id_exccode <= 5'd0;
    end else if (!stall) begin
      id_instr   <= legal ? rom_d : 32'd0;
      id_pc      <= pc;
      id_pc8     <= pc + 32'd8;
      id_valid   <= 1'b1;
      id_bd      <= br_in_id;
      id_exccode <= legal ? 5'd0 : EXC_ADEL;
    end
  end

endmodule
`default_nettype wire
